// File: rtl/collision_score_keeper.sv
// Per-frame collision and score keeper. It samples the sprite overlap flags during a frame
// and commits lives, BCD score and game-state changes on the end-of-frame tick.
module collision_score_keeper #(
  parameter int H_LAST        = 639,
  parameter int V_LAST        = 479,
  parameter int LIVES_INIT    = 3,
  parameter int BONUS_POINTS  = 1,
  parameter int INVULN_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pxl_x,
  input  logic [31:0] pxl_y,
  input  logic        draw_player,
  input  logic        draw_enemy,
  input  logic        draw_bonus,
  input  logic        Start,
  output logic [15:0] score_bcd,
  output logic [3:0]  lives,
  output logic        playing,
  output logic        game_over,
  output logic        invuln,
  output logic        hit_pulse,
  output logic        bonus_pulse
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAYING = 2'd1, S_GAME_OVER = 2'd2} state_t;

  localparam logic [31:0] H_LAST_C = 32'(H_LAST);
  localparam logic [31:0] V_LAST_C = 32'(V_LAST);
  localparam logic [3:0]  LIVES_C  = 4'(LIVES_INIT);
  localparam logic [3:0]  BONUS_C  = 4'(BONUS_POINTS);
  localparam logic [7:0]  INVULN_C = 8'(INVULN_FRAMES);

  // Digit-serial BCD add; a carry out of the thousands digit saturates at 9999.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [3:0] b);
    logic [15:0] r;
    logic [4:0]  s;
    logic [4:0]  c;
    c = {1'b0, b};
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[4*i +: 4]} + c;
      if (s > 5'd9) begin
        r[4*i +: 4] = 4'(s - 5'd10);
        c = 5'd1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c = 5'd0;
      end
    end
    if (c != 5'd0) begin
      r = 16'h9999;
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [3:0]  lives_q, lives_d;
  logic [7:0]  invuln_q, invuln_d;
  logic        hit_q, hit_d;
  logic        bonus_q, bonus_d;
  logic        enemy_flag_q, enemy_flag_d;
  logic        bonus_flag_q, bonus_flag_d;
  logic        start_prev_q;
  logic        at_last_q;

  logic at_last_s, frame_tick_s, start_rise_s;
  logic enemy_ov_s, bonus_ov_s, enemy_hit_s, in_play_s;

  assign at_last_s    = (pxl_x == H_LAST_C) && (pxl_y == V_LAST_C);
  assign frame_tick_s = at_last_s & ~at_last_q;
  assign start_rise_s = Start & ~start_prev_q;
  assign in_play_s    = (state_q == S_PLAYING);
  // The tick cycle's own pixel counts alongside the accumulated flag.
  assign enemy_ov_s   = enemy_flag_q | (draw_player & draw_enemy);
  assign bonus_ov_s   = bonus_flag_q | (draw_player & draw_bonus);
  assign enemy_hit_s  = in_play_s && frame_tick_s && enemy_ov_s && (invuln_q == 8'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start_rise_s) state_d = S_PLAYING;
        else              state_d = state_q;
      end
      S_PLAYING: begin
        if (enemy_hit_s && (lives_q <= 4'd1)) state_d = S_GAME_OVER;
        else                                  state_d = S_PLAYING;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    score_d      = score_q;
    lives_d      = lives_q;
    invuln_d     = invuln_q;
    hit_d        = 1'b0;
    bonus_d      = 1'b0;
    enemy_flag_d = 1'b0;
    bonus_flag_d = 1'b0;
    if (in_play_s) begin
      if (frame_tick_s) begin
        if (enemy_hit_s) begin
          lives_d  = lives_q - 4'd1;
          hit_d    = 1'b1;
          invuln_d = INVULN_C;
        end else if (invuln_q != 8'd0) begin
          invuln_d = invuln_q - 8'd1;
        end else begin
          invuln_d = invuln_q;
        end
        if (bonus_ov_s) begin
          score_d = bcd_add_sat(score_q, BONUS_C);
          bonus_d = 1'b1;
        end else begin
          score_d = score_q;
        end
      end else begin
        enemy_flag_d = enemy_ov_s;
        bonus_flag_d = bonus_ov_s;
      end
    end else if (start_rise_s) begin
      lives_d  = LIVES_C;
      score_d  = 16'h0000;
      invuln_d = INVULN_C;
    end else begin
      score_d = score_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q      <= 16'h0000;
      lives_q      <= 4'd0;
      invuln_q     <= 8'd0;
      hit_q        <= 1'b0;
      bonus_q      <= 1'b0;
      enemy_flag_q <= 1'b0;
      bonus_flag_q <= 1'b0;
      start_prev_q <= 1'b1;
      at_last_q    <= 1'b0;
    end else begin
      score_q      <= score_d;
      lives_q      <= lives_d;
      invuln_q     <= invuln_d;
      hit_q        <= hit_d;
      bonus_q      <= bonus_d;
      enemy_flag_q <= enemy_flag_d;
      bonus_flag_q <= bonus_flag_d;
      start_prev_q <= Start;
      at_last_q    <= at_last_s;
    end
  end

  assign score_bcd   = score_q;
  assign lives       = lives_q;
  assign playing     = (state_q == S_PLAYING);
  assign game_over   = (state_q == S_GAME_OVER);
  assign invuln      = (invuln_q != 8'd0);
  assign hit_pulse   = hit_q;
  assign bonus_pulse = bonus_q;

endmodule

// File: tb/tb_collision_score_keeper.sv
// Directed bench: a main instance with a short invulnerability window and a second instance
// with large bonus steps and no invulnerability for saturation and reset-discard checks.
module tb_collision_score_keeper;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pxl_x, pxl_y, s_pxl_x, s_pxl_y;
  logic        draw_player, draw_enemy, draw_bonus, Start;
  logic        s_player, s_enemy, s_bonus, s_start;
  logic [15:0] score_bcd, s_score;
  logic [3:0]  lives, s_lives;
  logic        playing, game_over, invuln, hit_pulse, bonus_pulse;
  logic        s_playing, s_game_over, s_invuln, s_hit, s_bonus_p;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  collision_score_keeper #(.H_LAST(639), .V_LAST(479), .LIVES_INIT(3), .BONUS_POINTS(1),
                           .INVULN_FRAMES(2)) u_dut (
    .clk(clk), .reset(reset), .pxl_x(pxl_x), .pxl_y(pxl_y),
    .draw_player(draw_player), .draw_enemy(draw_enemy), .draw_bonus(draw_bonus), .Start(Start),
    .score_bcd(score_bcd), .lives(lives), .playing(playing), .game_over(game_over),
    .invuln(invuln), .hit_pulse(hit_pulse), .bonus_pulse(bonus_pulse));

  collision_score_keeper #(.H_LAST(639), .V_LAST(479), .LIVES_INIT(3), .BONUS_POINTS(9),
                           .INVULN_FRAMES(0)) u_sat (
    .clk(clk), .reset(reset), .pxl_x(s_pxl_x), .pxl_y(s_pxl_y),
    .draw_player(s_player), .draw_enemy(s_enemy), .draw_bonus(s_bonus), .Start(s_start),
    .score_bcd(s_score), .lives(s_lives), .playing(s_playing), .game_over(s_game_over),
    .invuln(s_invuln), .hit_pulse(s_hit), .bonus_pulse(s_bonus_p));

  typedef struct {
    bit          en;
    bit          bo;
    logic [3:0]  lives;
    logic        inv;
    bit          inv_chk;
    logic        hit;
    logic        bon;
    logic [15:0] score;
    logic        pl;
    logic        go;
  } vec_t;

  vec_t vec[22];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One short frame: an overlap pixel, then the last-pixel cycle that ticks.
  task automatic main_frame(input bit en, input bit bo);
    pxl_x = 32'd10; pxl_y = 32'd10;
    draw_player = en | bo; draw_enemy = en; draw_bonus = bo;
    step();
    pxl_x = 32'd639; pxl_y = 32'd479;
    draw_player = 1'b0; draw_enemy = 1'b0; draw_bonus = 1'b0;
    step();
  endtask

  task automatic sat_frame(input bit bo);
    s_pxl_x = 32'd10; s_pxl_y = 32'd10; s_player = bo; s_bonus = bo;
    step();
    s_pxl_x = 32'd639; s_pxl_y = 32'd479; s_player = 1'b0; s_bonus = 1'b0;
    step();
  endtask

  function automatic vec_t mk(bit en, bit bo, logic [3:0] lv, logic inv, bit ic, logic h,
                              logic b, logic [15:0] sc, logic pl, logic go);
    vec_t v;
    v.en = en; v.bo = bo; v.lives = lv; v.inv = inv; v.inv_chk = ic; v.hit = h;
    v.bon = b; v.score = sc; v.pl = pl; v.go = go;
    return v;
  endfunction

  initial begin
    int hits;

    vec[0] = mk(1, 0, 4'd3, 1'b1, 1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    vec[1] = mk(1, 0, 4'd3, 1'b0, 1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    vec[2] = mk(1, 0, 4'd2, 1'b1, 1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    vec[3] = mk(1, 0, 4'd2, 1'b1, 1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    vec[4] = mk(0, 0, 4'd2, 1'b0, 1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      vec[4+k] = mk(0, 1, 4'd2, 1'b0, 1, 1'b0, 1'b1,
                    16'((k / 10) * 16 + (k % 10)), 1'b1, 1'b0);
    end
    vec[17] = mk(1, 1, 4'd1, 1'b1, 1, 1'b1, 1'b1, 16'h0013, 1'b1, 1'b0);
    vec[18] = mk(0, 0, 4'd1, 1'b1, 1, 1'b0, 1'b0, 16'h0013, 1'b1, 1'b0);
    vec[19] = mk(0, 0, 4'd1, 1'b0, 1, 1'b0, 1'b0, 16'h0013, 1'b1, 1'b0);
    vec[20] = mk(1, 1, 4'd0, 1'b1, 1, 1'b1, 1'b1, 16'h0014, 1'b0, 1'b1);
    vec[21] = mk(1, 1, 4'd0, 1'b0, 0, 1'b0, 1'b0, 16'h0014, 1'b0, 1'b1);

    reset = 1'b1; Start = 1'b1; s_start = 1'b1;
    pxl_x = 32'd0; pxl_y = 32'd0; draw_player = 1'b0; draw_enemy = 1'b0; draw_bonus = 1'b0;
    s_pxl_x = 32'd0; s_pxl_y = 32'd0; s_player = 1'b0; s_enemy = 1'b0; s_bonus = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();
    chk("held_start_playing", 16'(playing), 16'd0);
    chk("held_start_lives", 16'(lives), 16'd0);
    chk("held_start_score", score_bcd, 16'h0000);
    chk("held_start_invuln", 16'(invuln), 16'd0);
    chk("held_start_game_over", 16'(game_over), 16'd0);

    Start = 1'b0; s_start = 1'b0;
    step();
    Start = 1'b1; s_start = 1'b1;
    step();
    chk("start_playing", 16'(playing), 16'd1);
    chk("start_lives", 16'(lives), 16'd3);
    chk("start_score", score_bcd, 16'h0000);
    chk("start_invuln", 16'(invuln), 16'd1);
    chk("sat_start_invuln", 16'(s_invuln), 16'd0);

    for (int i = 0; i < 22; i++) begin
      main_frame(vec[i].en, vec[i].bo);
      chk($sformatf("v%0d_lives", i), 16'(lives), 16'(vec[i].lives));
      if (vec[i].inv_chk) chk($sformatf("v%0d_invuln", i), 16'(invuln), 16'(vec[i].inv));
      chk($sformatf("v%0d_hit", i), 16'(hit_pulse), 16'(vec[i].hit));
      chk($sformatf("v%0d_bonus", i), 16'(bonus_pulse), 16'(vec[i].bon));
      chk($sformatf("v%0d_score", i), score_bcd, vec[i].score);
      chk($sformatf("v%0d_playing", i), 16'(playing), 16'(vec[i].pl));
      chk($sformatf("v%0d_game_over", i), 16'(game_over), 16'(vec[i].go));
      pxl_x = 32'd0; pxl_y = 32'd0;
      step();
      chk($sformatf("v%0d_pulses_clear", i), {14'd0, hit_pulse, bonus_pulse}, 16'd0);
    end

    Start = 1'b0;
    step();
    Start = 1'b1;
    step();
    chk("restart_playing", 16'(playing), 16'd1);
    chk("restart_lives", 16'(lives), 16'd3);
    chk("restart_score", score_bcd, 16'h0000);
    chk("restart_game_over", 16'(game_over), 16'd0);

    // Wait out the invulnerability window, then overlap only on the held last pixel.
    repeat (2) begin
      main_frame(0, 0);
      pxl_x = 32'd0; pxl_y = 32'd0;
      step();
    end
    chk("held_pre_invuln", 16'(invuln), 16'd0);
    hits = 0;
    pxl_x = 32'd639; pxl_y = 32'd479; draw_player = 1'b1; draw_enemy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (hit_pulse) hits++;
    end
    pxl_x = 32'd0; pxl_y = 32'd0; draw_player = 1'b0; draw_enemy = 1'b0;
    step();
    if (hit_pulse) hits++;
    chk("held_hit_count", 16'(hits), 16'd1);
    chk("held_lives", 16'(lives), 16'd2);

    Start = 1'b0;
    step();
    Start = 1'b1;
    step();
    chk("start_in_play_lives", 16'(lives), 16'd2);
    chk("start_in_play_invuln", 16'(invuln), 16'd1);

    for (int k = 1; k <= 1112; k++) begin
      sat_frame(1);
      if (k == 2)    chk("sat_18", s_score, 16'h0018);
      if (k == 1110) chk("sat_9990", s_score, 16'h9990);
      if (k == 1111) chk("sat_9999", s_score, 16'h9999);
      if (k == 1112) chk("sat_hold", s_score, 16'h9999);
    end
    chk("sat_bonus_pulse", 16'(s_bonus_p), 16'd1);

    // Leave an enemy flag pending in both instances, then reset mid-frame.
    pxl_x = 32'd10; pxl_y = 32'd10; draw_player = 1'b1; draw_enemy = 1'b1;
    s_pxl_x = 32'd10; s_pxl_y = 32'd10; s_player = 1'b1; s_enemy = 1'b1;
    step();
    reset = 1'b1;
    #1;
    chk("rst_score", score_bcd, 16'h0000);
    chk("rst_lives", 16'(lives), 16'd0);
    chk("rst_flags", {11'd0, playing, game_over, invuln, hit_pulse, bonus_pulse}, 16'd0);
    chk("rst_sat_score", s_score, 16'h0000);
    chk("rst_sat_lives", 16'(s_lives), 16'd0);
    draw_player = 1'b0; draw_enemy = 1'b0; s_player = 1'b0; s_enemy = 1'b0;
    s_pxl_x = 32'd0; s_pxl_y = 32'd0; Start = 1'b0; s_start = 1'b0;
    step();
    reset = 1'b0;
    step();
    Start = 1'b1; s_start = 1'b1;
    step();
    chk("rst_restart_lives", 16'(s_lives), 16'd3);
    s_pxl_x = 32'd639; s_pxl_y = 32'd479;
    step();
    chk("rst_no_hit_pulse", 16'(s_hit), 16'd0);
    chk("rst_no_hit_lives", 16'(s_lives), 16'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/collision_score_keeper.md
Name: collision_score_keeper

Overview:
- Per-frame game-state keeper that sits downstream of the sprite units and alongside the drawing priority mux.
- Samples the raw per-pixel draw flags of the player, enemy and bonus objects, and detects overlaps during each frame.
- At end of frame it commits the results: lives lost, BCD score gained, game-state transitions.
- Outputs feed the HEX0-HEX3 seven-segment decoders, the LEDs, and the sprite units (invulnerability blink, reset of positions on hit).

Parameters:
- H_LAST, 639, last active pixel column.
- V_LAST, 479, last active pixel row.
- LIVES_INIT, 3, lives loaded on game start (1..9).
- BONUS_POINTS, 1, BCD points added per bonus collision frame (1..9).
- INVULN_FRAMES, 60, frames of enemy-collision immunity after a life is lost (0..255).

Ports:
- clk  in  1  pixel clock (25 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- pxl_x  in  32  current pixel column from screen controller.
- pxl_y  in  32  current pixel row.
- draw_player  in  1  player object drawing this pixel.
- draw_enemy  in  1  enemy object drawing this pixel.
- draw_bonus  in  1  bonus object drawing this pixel.
- Start  in  1  start button level (already synchronised).
- score_bcd  out  16  4 BCD digits, [15:12] thousands … [3:0] units.
- lives  out  4  remaining lives, binary.
- playing  out  1  state == PLAYING.
- game_over  out  1  state == GAME_OVER.
- invuln  out  1  invulnerability counter non-zero.
- hit_pulse  out  1  one-cycle pulse: life lost this frame.
- bonus_pulse  out  1  one-cycle pulse: bonus scored this frame.

Behaviour:
Reset:
- Asynchronous; state = IDLE, score_bcd = 0, lives = 0, invuln counter = 0, both pulses 0, collision flags 0.
- start_prev = 1, so a Start held through reset does not trigger a start.

Start edge:
- start_rise = Start & ~start_prev.
- start_prev is registered every cycle.

Frame tick:
- at_last = (pxl_x == H_LAST) && (pxl_y == V_LAST).
- frame_tick = at_last & ~at_last_d, where at_last_d is a registered copy of at_last. Exactly one tick per frame, even if coordinates hold for several clocks.

Collision flags:
- enemy_flag is set in any cycle with draw_player & draw_enemy.
- bonus_flag is set in any cycle with draw_player & draw_bonus.
- The tick cycle's own pixel counts: commit uses flag | current-cycle overlap.
- Both flags clear on frame_tick, and clear in every state other than PLAYING.

States:
- IDLE: start_rise -> PLAYING; load lives = LIVES_INIT, score = 0, invuln counter = INVULN_FRAMES.
- PLAYING, on frame_tick, all committed on the same edge (outputs visible the cycle after the tick cycle):
  - enemy hit = enemy overlap && invuln counter == 0. Then lives -= 1, hit_pulse = 1, invuln counter = INVULN_FRAMES.
  - Otherwise, if the invuln counter is non-zero, it decrements by 1.
  - bonus overlap → score += BONUS_POINTS (BCD), bonus_pulse = 1. Bonus scores even while invulnerable.
  - Enemy and bonus in the same frame: both apply.
  - If lives reaches 0 on this tick → GAME_OVER (bonus from the same frame is still added).
- GAME_OVER: score and lives hold (lives = 0). start_rise → PLAYING with the same loads as from IDLE.
- start_rise while PLAYING is ignored.

BCD arithmetic:
- Per-digit add with carry: a digit sum > 9 subtracts 10 and carries 1.
- Score saturates at 9999: if the add would overflow the thousands digit, the result is 16'h9999.
- score_bcd digits are never > 9.

Outputs and widths:
- Pulses are high for exactly one clock, and only in PLAYING.
- The invuln counter is 8 bits wide.
- pxl comparisons are full 32-bit unsigned.

Reset mid-operation: an immediate return to the reset values; pending flags are discarded.

Test Plan:
- Reset with Start=1, release reset, hold Start → state stays IDLE, lives=0. Drop then raise Start → playing=1, lives=3, score=0000, invuln=1.
- INVULN_FRAMES=2, overlap player/enemy for 1 pixel in each of frames 1..4:
  - frames 1-2 ignored, invuln=0 after frame 2 tick;
  - frame 3 → hit_pulse single cycle, lives=2, invuln=1;
  - frame 4 ignored.
- Bonus overlap in 12 consecutive frames, BONUS_POINTS=1 → score_bcd=16'h0012, bonus_pulse 12 times. Preload 0x9998 with BONUS_POINTS=5 → 0x9999 (saturated).
- Overlap only at pixel (639,479), coords held 3 clocks → exactly one frame_tick, one hit, lives decrement by 1 (not 3).
- lives=1, invuln=0, enemy and bonus overlap in the same frame:
  - lives=0, score +1, both pulses in the same cycle, game_over=1;
  - a further Start rise → playing, lives=3, score=0000.
- Assert reset mid-frame after a collision flag was set → all outputs at reset values immediately. After restart, the next frame tick produces no hit.
